// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the Booth dot-product sequencer.
// Contents: FSM state encoding, default multiplier latency, operand/product widths.
// No ports; imported by booth_valid_pipe and booth_dot_sequencer.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MUL_LAT_DEF = 3;
  localparam int OPND_W      = 8;
  localparam int PROD_W      = 16;

endpackage

// File: rtl/booth_valid_pipe.sv
// booth_valid_pipe: LAT-deep shift register tracking which multiplier slots hold real pairs.
// Ports: clk/rst_n, vld_i (bit entering this edge), vld_o (bit leaving, aligned with the
// product), any_valid_o (some valid bit will still be in the pipe after this edge).
module booth_valid_pipe
  import booth_pkg::*;
#(
  parameter int LAT = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_i,
  output logic vld_o,
  output logic any_valid_o
);

  logic [LAT-1:0] pipe_q;
  logic [LAT-1:0] pipe_d;

  // Shift towards the MSB; the MSB is the slot whose product is on prdct_i now.
  assign pipe_d      = LAT'({pipe_q, vld_i});
  assign vld_o       = pipe_q[LAT-1];
  // Looks at the next-state contents so the caller can leave DRAIN on the
  // same edge that consumes the final product.
  assign any_valid_o = |pipe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: rtl/booth_dot_sequencer.sv
// booth_dot_sequencer: feeds signed 8-bit pairs to an external pipelined Booth multiplier
// and accumulates the returned products into a signed ACC_W-bit dot product.
// Ports: start_i/len_i/busy_o frame control; in_valid_i/in_ready_o/a_i/b_i operand
// handshake; mul_a_o/mul_b_o/prdct_i multiplier link; res_valid_o/res_ready_i/res_o result.
module booth_dot_sequencer
  import booth_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9,
  parameter int ACC_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  output logic [OPND_W-1:0] mul_a_o,
  output logic [OPND_W-1:0] mul_b_o,
  input  logic [PROD_W-1:0] prdct_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [ACC_W-1:0]  res_o
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              fire;
  logic              pipe_out;
  logic              pipe_any;
  logic [ACC_W-1:0]  prod_ext;

  // The multiplier registers its operands itself; no staging here.
  assign mul_a_o = a_i;
  assign mul_b_o = b_i;

  assign in_ready_o  = (state_q == ST_RUN) && (cnt_q < len_q);
  assign fire        = in_valid_i && in_ready_o;
  assign busy_o      = (state_q != ST_IDLE);
  assign res_valid_o = (state_q == ST_DONE);
  assign res_o       = acc_q;
  assign prod_ext    = {{(ACC_W-PROD_W){prdct_i[PROD_W-1]}}, prdct_i};

  booth_valid_pipe #(
    .LAT (MUL_LAT)
  ) u_vpipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld_i       (fire),
    .vld_o       (pipe_out),
    .any_valid_o (pipe_any)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    // Products only ever emerge in RUN/DRAIN; the state gate keeps DONE's result frozen.
    if (pipe_out && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
      acc_d = acc_q + prod_ext;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          // Out-of-range lengths are clamped so the frame always terminates.
          len_d   = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (len_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!pipe_any) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_booth_dot_sequencer.sv
// tb_booth_dot_sequencer: bench for booth_dot_sequencer with a behavioural 3-stage
// multiplier between mul_*_o and prdct_i; expected dot products queued at frame start.
// Ports: none (top-level bench).
module tb_booth_dot_sequencer;
  import booth_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int LEN_W   = 9;
  localparam int ACC_W   = 24;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start_i = 1'b0;
  logic [LEN_W-1:0]        len_i = '0;
  logic                    busy_o;
  logic                    in_valid_i = 1'b0;
  logic                    in_ready_o;
  logic signed [7:0]       a_i = '0;
  logic signed [7:0]       b_i = '0;
  logic signed [7:0]       mul_a;
  logic signed [7:0]       mul_b;
  logic signed [15:0]      prdct;
  logic                    res_valid_o;
  logic                    res_ready_i = 1'b0;
  logic [ACC_W-1:0]        res_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [ACC_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  booth_dot_sequencer #(
    .MUL_LAT (MUL_LAT),
    .MAX_LEN (256),
    .LEN_W   (LEN_W),
    .ACC_W   (ACC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .prdct_i     (prdct),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_o       (res_o)
  );

  // Behavioural multiplier: operands captured every edge, product valid MUL_LAT edges later.
  logic signed [15:0] mp [MUL_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) mp[i] <= '0;
    end else begin
      mp[0] <= mul_a * mul_b;
      for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign prdct = mp[MUL_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    start_i = 1'b1;
    len_i   = LEN_W'(len);
    tick();
    start_i = 1'b0;
  endtask

  // Waits for res_valid_o; lat = edges elapsed (500 means it never came).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid_o && lat < 500) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_i   = 8'sh5A;
    b_i   = -8'sd3;
    #2;
    vectors++;
    if ({busy_o, in_ready_o, res_valid_o} !== 3'b000 || res_o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy/rdy/vld=%b res=%h, required 000 res=000000",
               {busy_o, in_ready_o, res_valid_o}, res_o);
    end
    vectors++;
    if (mul_a !== 8'sh5A || mul_b !== -8'sd3) begin
      miscompares++;
      $display("FAIL reset_mul_passthru: mul_a=%h mul_b=%h, required 5a fd", mul_a, mul_b);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] pa [4] = '{8'sd1, 8'sd3, -8'sd5, 8'sd7};
    logic signed [7:0] pb [4] = '{8'sd2, 8'sd4, 8'sd6, -8'sd8};
    int lat;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(24'hFFFFB8);
    start_frame(4);
    vectors++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_after_start: rdy=%b busy=%b, required 1 1", in_ready_o, busy_o);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      a_i = pa[i];
      b_i = pb[i];
      tick();
    end
    in_valid_i = 1'b0;
    vectors++;
    if (in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_drain_ready: rdy=%b busy=%b, required 0 1", in_ready_o, busy_o);
    end
    wait_result(lat);
    vectors++;
    if (lat != MUL_LAT) begin
      miscompares++;
      $display("FAIL b2b_latency: res_valid after %0d edges, required %0d", lat, MUL_LAT);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (res_o !== exp) begin
      miscompares++;
      $display("FAIL b2b_result: res_o=%h, required %h", res_o, exp);
    end
    handshake();
    vectors++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_after_hs: busy=%b vld=%b, required 0 0", busy_o, res_valid_o);
    end
  endtask

  task automatic test_full_len();
    int lat;
    int not_ready = 0;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(24'h400000);
    start_frame(256);
    in_valid_i = 1'b1;
    a_i = -8'sd128;
    b_i = -8'sd128;
    for (int i = 0; i < 256; i++) begin
      if (in_ready_o !== 1'b1) not_ready++;
      tick();
    end
    in_valid_i = 1'b0;
    vectors++;
    if (not_ready != 0 || in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready_window: %0d low cycles, rdy after=%b, required 0 0",
               not_ready, in_ready_o);
    end
    wait_result(lat);
    vectors++;
    if (lat != MUL_LAT) begin
      miscompares++;
      $display("FAIL full_latency: res_valid after %0d edges, required %0d", lat, MUL_LAT);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (res_o !== exp) begin
      miscompares++;
      $display("FAIL full_result: res_o=%h, required %h", res_o, exp);
    end
    handshake();
  endtask

  task automatic test_gaps();
    logic signed [7:0] pa [3] = '{8'sd10, -8'sd1, 8'sd127};
    logic signed [7:0] pb [3] = '{8'sd10, 8'sd1, 8'sd127};
    int lat;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(24'd16228);
    start_frame(3);
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      a_i = pa[i];
      b_i = pb[i];
      tick();
      if (i < 2) begin
        // Junk operands on idle cycles must never reach the sum.
        in_valid_i = 1'b0;
        a_i = 8'sd99;
        b_i = 8'sd99;
        tick();
        tick();
      end
    end
    in_valid_i = 1'b0;
    a_i = 8'sd99;
    b_i = 8'sd99;
    wait_result(lat);
    vectors++;
    if (lat != MUL_LAT) begin
      miscompares++;
      $display("FAIL gaps_latency: res_valid after %0d edges, required %0d", lat, MUL_LAT);
    end
    exp = exp_q.pop_front();
    vectors++;
    if (res_o !== exp) begin
      miscompares++;
      $display("FAIL gaps_result: res_o=%0d, required %0d", res_o, exp);
    end
    handshake();
  endtask

  task automatic test_len_zero();
    logic [ACC_W-1:0] exp;
    exp_q.push_back('0);
    in_valid_i = 1'b1;
    start_frame(0);
    exp = exp_q.pop_front();
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp || in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_result: vld=%b res=%h rdy=%b, required 1 %h 0",
               res_valid_o, res_o, in_ready_o, exp);
    end
    handshake();
    in_valid_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_idle: busy=%b rdy=%b, required 0 0", busy_o, in_ready_o);
    end
  endtask

  task automatic test_hold_done();
    int lat;
    int bad = 0;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(24'd1);
    start_frame(2);
    in_valid_i = 1'b1;
    a_i = 8'sd5;  b_i = -8'sd3; tick();
    a_i = 8'sd4;  b_i = 8'sd4;  tick();
    in_valid_i = 1'b0;
    wait_result(lat);
    exp = exp_q.pop_front();
    vectors++;
    if (res_valid_o !== 1'b1 || res_o !== exp) begin
      miscompares++;
      $display("FAIL hold_result: vld=%b res=%h, required 1 %h", res_valid_o, res_o, exp);
    end
    start_i = 1'b1;
    len_i   = 9'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_valid_o !== 1'b1 || res_o !== exp || in_ready_o !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold_stable: %0d cycles changed (res=%h rdy=%b), required 0",
               bad, res_o, in_ready_o);
    end
    // Start coincident with the handshake is ignored too.
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    start_i     = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_start_ignored: busy=%b vld=%b, required 0 0", busy_o, res_valid_o);
    end
    tick();
  endtask

  task automatic test_reset_drain();
    int lat;
    logic [ACC_W-1:0] exp;
    exp_q.push_back(24'd4);
    start_frame(4);
    in_valid_i = 1'b1;
    a_i = 8'sd1;
    b_i = 8'sd1;
    for (int i = 0; i < 4; i++) tick();
    in_valid_i = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    vectors++;
    if ({busy_o, in_ready_o, res_valid_o} !== 3'b000 || res_o !== '0) begin
      miscompares++;
      $display("FAIL drain_reset: busy/rdy/vld=%b res=%h, required 000 000000",
               {busy_o, in_ready_o, res_valid_o}, res_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(24'd6);
    start_frame(1);
    in_valid_i = 1'b1;
    a_i = 8'sd2;
    b_i = 8'sd3;
    tick();
    in_valid_i = 1'b0;
    wait_result(lat);
    exp = exp_q.pop_front();
    vectors++;
    if (lat != MUL_LAT || res_o !== exp) begin
      miscompares++;
      $display("FAIL post_reset_frame: lat=%0d res=%0d, required %0d %0d",
               lat, res_o, MUL_LAT, exp);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_len();
    test_gaps();
    test_len_zero();
    test_hold_done();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
